// File: rtl/quad_encoder_tx.sv
// Quadrature encoder emulator: emits N Gray-code steps on enc_a/enc_b in the
// requested direction, holding each state STEP_DIV clocks, then settles and pulses done.
module quad_encoder_tx #(
    parameter int STEP_DIV = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_steps,
    output logic             enc_a,
    output logic             enc_b,
    output logic             busy,
    output logic             done
);
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] remaining;
    logic             dir;
    logic             div_tc;

    assign div_tc = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            div       <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            enc_a     <= 1'b0;
            enc_b     <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        dir       <= req_dir;
                        remaining <= req_steps;
                        div       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (req_steps == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (div_tc) begin
                        div <= '0;
                        // CW: (A,B) -> (~B,A); CCW: (A,B) -> (B,~A). One bit flips per step.
                        if (dir) begin
                            enc_a <= ~enc_b;
                            enc_b <= enc_a;
                        end else begin
                            enc_a <= enc_b;
                            enc_b <= ~enc_a;
                        end
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1))
                            state <= SETTLE;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                SETTLE: begin
                    if (div_tc) begin
                        div   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                DONE: begin
                    // A zero-step request arrives here with done low and spends one extra cycle.
                    if (done) begin
                        done      <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quad_encoder_tx.sv
// Bench for quad_encoder_tx: timeline model of each request plus literal
// spot checks (STEP_DIV=4 instance) and a Gray/net-position monitor (STEP_DIV=2 instance).
module tb_quad_encoder_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v0, d0, rdy0, a0, b0, busy0, done0;
    logic [7:0] s0;
    logic       v1, d1, rdy1, a1, b1, busy1, done1;
    logic [7:0] s1;

    quad_encoder_tx #(.STEP_DIV(4), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_dir(d0),
        .req_steps(s0), .enc_a(a0), .enc_b(b0), .busy(busy0), .done(done0));

    quad_encoder_tx #(.STEP_DIV(2), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_dir(d1),
        .req_steps(s1), .enc_a(a1), .enc_b(b1), .busy(busy1), .done(done1));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request timeline model: position = start + sign*min(t/D, N) cycles after accept.
    int D[2] = '{4, 2};
    bit act[2];
    int t[2], start[2], sgn[2], n[2], pos[2];

    function automatic int tdone(int i);
        return (n[i] == 0) ? 1 : D[i] * (n[i] + 1);
    endfunction

    function automatic int epos(int i);
        int k;
        if (!act[i]) return pos[i];
        k = t[i] / D[i];
        if (k > n[i]) k = n[i];
        return start[i] + sgn[i] * k;
    endfunction

    function automatic logic [1:0] gray(int p);
        case (((p % 4) + 4) % 4)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int gidx(logic [1:0] g);
        case (g)
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic mstep(int i, logic rn, logic v, logic dr, logic [7:0] st);
        if (!rn) begin
            act[i] = 0;
            pos[i] = 0;
        end else if (act[i]) begin
            t[i]++;
            if (t[i] > tdone(i)) begin
                pos[i] = epos(i);
                act[i] = 0;
            end
        end else if (v) begin
            act[i]   = 1;
            t[i]     = 0;
            start[i] = pos[i];
            sgn[i]   = dr ? 1 : -1;
            n[i]     = int'(st);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        mstep(0, rst_n, v0, d0, s0);
        mstep(1, rst_n, v1, d1, s1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("enc0",   {a0, b0}, gray(epos(0)));
            chk("done0",  done0,    act[0] && t[0] == tdone(0));
            chk("busy0",  busy0,    act[0]);
            chk("ready0", rdy0,     !act[0]);
            chk("enc1",   {a1, b1}, gray(epos(1)));
            chk("done1",  done1,    act[1] && t[1] == tdone(1));
            chk("busy1",  busy1,    act[1]);
            chk("ready1", rdy1,     !act[1]);
        end
    end

    // Per-cycle log of instance 0 for literal checks: {a,b,done,busy,ready}.
    logic [4:0] lg [16384];
    bit saw_done0;
    always @(negedge clk) begin
        if (cyc < 16384) lg[cyc] = {a0, b0, done0, busy0, rdy0};
        if (done0) saw_done0 = 1;
    end

    // Gray / hold / net-position monitor on instance 1.
    logic [1:0] prv1 = 2'b00;
    int net1 = 0;
    int lastchg = -1000;
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                net1 = 0;
            end else if ({a1, b1} !== prv1) begin
                int dlt;
                chk("gray1_onebit", $countones({a1, b1} ^ prv1), 1);
                chk("gray1_hold_ok", (cyc - lastchg) >= 2, 1);
                dlt = (gidx({a1, b1}) - gidx(prv1) + 4) % 4;
                if (dlt == 1) net1++;
                else if (dlt == 3) net1--;
                lastchg = cyc;
            end
            prv1 = {a1, b1};
        end
    end

    task automatic lit_ab(string nm, int acc, int k, logic [1:0] ab);
        chk(nm, lg[acc + k][4:3], ab);
    endtask

    task automatic lit_bit(string nm, int acc, int k, int b, logic val);
        chk(nm, lg[acc + k][b], val);
    endtask

    task automatic req0(logic dir, int steps, bit hold, output int acc);
        @(negedge clk);
        #1 v0 = 1; d0 = dir; s0 = 8'(steps);
        @(posedge clk);
        #1 acc = cyc;
        if (!hold) v0 = 0;
    endtask

    task automatic wait_idle0(string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rdy0 && k < 3000);
        if (!rdy0) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_idle1(string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rdy1 && k < 3000);
        if (!rdy1) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int exp_net;
        rst_n = 0;
        v0 = 0; d0 = 0; s0 = 0;
        v1 = 0; d1 = 0; s1 = 0;
        @(posedge clk);
        #1 chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_enc", {a0, b0}, 2'b00);
        chk("rst_ready", rdy0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);

        // CW 4 from 00
        req0(1, 4, 0, acc);
        wait_idle0("cw4");
        lit_ab("cw4_c4", acc, 4, 2'b10);
        lit_ab("cw4_c8", acc, 8, 2'b11);
        lit_ab("cw4_c12", acc, 12, 2'b01);
        lit_ab("cw4_c16", acc, 16, 2'b00);
        lit_ab("cw4_c3", acc, 3, 2'b00);
        lit_bit("cw4_done19", acc, 19, 2, 0);
        lit_bit("cw4_done20", acc, 20, 2, 1);
        lit_bit("cw4_ready20", acc, 20, 0, 0);
        lit_bit("cw4_ready21", acc, 21, 0, 1);
        lit_bit("cw4_busy0", acc, 0, 1, 1);
        lit_bit("cw4_busy20", acc, 20, 1, 1);

        // CCW 3 from 00, then CW 1
        req0(0, 3, 0, acc);
        wait_idle0("ccw3");
        lit_ab("ccw3_c4", acc, 4, 2'b01);
        lit_ab("ccw3_c8", acc, 8, 2'b11);
        lit_ab("ccw3_c12", acc, 12, 2'b10);
        lit_bit("ccw3_done16", acc, 16, 2, 1);
        req0(1, 1, 0, acc);
        wait_idle0("cw1");
        lit_ab("cw1_c4", acc, 4, 2'b11);

        // zero steps
        req0(1, 0, 0, acc);
        wait_idle0("n0");
        lit_bit("n0_done0", acc, 0, 2, 0);
        lit_bit("n0_done1", acc, 1, 2, 1);
        lit_bit("n0_ready1", acc, 1, 0, 0);
        lit_bit("n0_ready2", acc, 2, 0, 1);
        lit_ab("n0_enc1", acc, 1, 2'b11);

        // backpressure: new dir/steps while running are ignored, then accepted after DONE
        req0(1, 1, 1, acc);
        repeat (2) @(posedge clk);
        #1 d0 = 0; s0 = 8'd2;
        repeat (8) @(posedge clk);
        #1 v0 = 0;
        wait_idle0("bp");
        lit_ab("bp_c4", acc, 4, 2'b01);
        lit_ab("bp_c7", acc, 7, 2'b01);
        lit_bit("bp_done8", acc, 8, 2, 1);
        lit_bit("bp_ready9", acc, 9, 0, 1);
        lit_bit("bp_busy10", acc, 10, 1, 1);
        lit_ab("bp_c14", acc, 14, 2'b11);
        lit_ab("bp_c18", acc, 18, 2'b10);
        lit_bit("bp_done22", acc, 22, 2, 1);

        // reset mid-run
        req0(1, 4, 0, acc);
        repeat (6) @(posedge clk);
        #1 rst_n = 0; saw_done0 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (4) @(negedge clk);
        chk("rstrun_enc", {a0, b0}, 2'b00);
        chk("rstrun_ready", rdy0, 1);
        chk("rstrun_busy", busy0, 0);
        chk("rstrun_nodone", saw_done0, 0);

        // long Gray runs with random direction on the STEP_DIV=2 instance
        exp_net = 0;
        for (int r = 0; r < 4; r++) begin
            logic dr;
            dr = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1 v1 = 1; d1 = dr; s1 = 8'd255;
            @(posedge clk);
            #1 v1 = 0;
            wait_idle1("gray");
            exp_net += dr ? 255 : -255;
        end
        chk("gray1_net", net1, exp_net);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
